// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin arbiter sharing one Wishbone classic slave among NM masters
// Optional slave-timeout path enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int NM    = 2,
    parameter int AW    = 12,
    parameter int TMO_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NM*(AW-2)-1:0] i_m_adr,
    input  logic [NM*32-1:0]     i_m_dat,
    input  logic [NM*4-1:0]      i_m_sel,
    input  logic [NM-1:0]        i_m_we,
    input  logic [NM-1:0]        i_m_cyc,
    input  logic [NM-1:0]        i_m_stb,
    output logic [31:0]          o_m_rdt,
    output logic [NM-1:0]        o_m_ack,
    output logic [NM-1:0]        o_m_err,
    output logic [AW-3:0]        o_wb_adr,
    output logic [31:0]          o_wb_dat,
    output logic [3:0]           o_wb_sel,
    output logic                 o_wb_we,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    input  logic [31:0]          i_wb_rdt,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err
);

    localparam int WA = AW - 2;
    localparam int PW = (NM > 1) ? $clog2(NM) : 1;

    if ((NM < 2) || (NM > 8) || (TMO_W < 1)) begin : g_param_range_bad
        logic param_range_bad;
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1
`ifdef WB_ARB_TIMEOUT_EN
        ,
        TERR = 2'd2
`endif
    } state_t;

    state_t        cs_q;
    logic [NM-1:0] grant_q;
    logic [NM-1:0] grant_d;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] own_idx;
    logic          own_cyc;

    logic [WA-1:0] adr_mux;
    logic [31:0]   dat_mux;
    logic [3:0]    sel_mux;
    logic          we_mux;
    logic          cyc_mux;
    logic          stb_mux;

    // First requester at or after ptr, scanning cyclically.
    always_comb begin
        logic found;
        grant_d = '0;
        found   = 1'b0;
        for (int i = 0; i < NM; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % NM;
            if (!found && i_m_cyc[idx]) begin
                grant_d[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        own_idx = '0;
        for (int k = 0; k < NM; k++) begin
            if (grant_q[k]) begin
                own_idx = PW'(k);
            end
        end
    end

    assign own_cyc = |(i_m_cyc & grant_q);
    assign ptr_d   = (own_idx == PW'(NM - 1)) ? '0 : own_idx + 1'b1;

    // AND-OR mux keyed by the one-hot grant; all-zero when nobody owns the bus.
    always_comb begin
        adr_mux = '0;
        dat_mux = '0;
        sel_mux = '0;
        for (int k = 0; k < NM; k++) begin
            adr_mux = adr_mux | (i_m_adr[k*WA +: WA] & {WA{grant_q[k]}});
            dat_mux = dat_mux | (i_m_dat[k*32 +: 32] & {32{grant_q[k]}});
            sel_mux = sel_mux | (i_m_sel[k*4 +: 4]   & {4{grant_q[k]}});
        end
    end

    assign we_mux  = |(i_m_we  & grant_q);
    assign cyc_mux = |(i_m_cyc & grant_q);
    assign stb_mux = |(i_m_stb & grant_q);

    assign o_wb_adr = adr_mux;
    assign o_wb_dat = dat_mux;
    assign o_wb_sel = sel_mux;
    assign o_wb_we  = we_mux;
    assign o_m_rdt  = i_wb_rdt;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO = '1;

    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;
    logic             route_ok;

    assign tmo_hit  = (cs_q == BUSY) && (tmo_q == TMO);
    // On the timeout cycle the slave is cut off and the owner sees a synthetic error.
    assign route_ok = (cs_q == BUSY) && !tmo_hit;

    assign o_wb_cyc = cyc_mux & route_ok;
    assign o_wb_stb = stb_mux & route_ok;
    assign o_m_ack  = grant_q & {NM{i_wb_ack & route_ok}};
    assign o_m_err  = grant_q & {NM{(i_wb_err & route_ok) | tmo_hit}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_q    <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            tmo_q   <= '0;
        end else begin
            case (cs_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (|i_m_cyc) begin
                        grant_q <= grant_d;
                        cs_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!own_cyc) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
                        tmo_q   <= '0;
                        cs_q    <= IDLE;
                    end else if (tmo_hit) begin
                        tmo_q <= '0;
                        cs_q  <= TERR;
                    end else if (i_wb_ack || i_wb_err) begin
                        tmo_q <= '0;
                    end else if (stb_mux) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                TERR: begin
                    if (!own_cyc) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
                        cs_q    <= IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    tmo_q   <= '0;
                    cs_q    <= IDLE;
                end
            endcase
        end
    end
`else
    assign o_wb_cyc = cyc_mux;
    assign o_wb_stb = stb_mux;
    assign o_m_ack  = grant_q & {NM{i_wb_ack}};
    assign o_m_err  = grant_q & {NM{i_wb_err}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cs_q    <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            case (cs_q)
                IDLE: begin
                    if (|i_m_cyc) begin
                        grant_q <= grant_d;
                        cs_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!own_cyc) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
                        cs_q    <= IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    cs_q    <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - self-checking bench for wb_rr_arbiter (NM=2, AW=12, TMO_W=4)
module tb_wb_rr_arbiter;

    localparam int NM    = 2;
    localparam int AW    = 12;
    localparam int TMO_W = 4;

    localparam logic [9:0]  M0_ADR = 10'h003;
    localparam logic [31:0] M0_DAT = 32'hA5A5_A5A5;
    localparam logic [3:0]  M0_SEL = 4'hF;
    localparam logic [9:0]  M1_ADR = 10'h2A5;
    localparam logic [31:0] M1_DAT = 32'h5A5A_0001;
    localparam logic [3:0]  M1_SEL = 4'h3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    m_cyc = '0;
    logic [1:0]    m_stb = '0;
    logic [1:0]    m_we = '0;
    logic [31:0]   wb_rdt = '0;
    logic          wb_ack = 1'b0;
    logic          wb_err = 1'b0;
    logic [31:0]   m_rdt;
    logic [1:0]    m_ack;
    logic [1:0]    m_err;
    logic [9:0]    wb_adr;
    logic [31:0]   wb_dat;
    logic [3:0]    wb_sel;
    logic          wb_we;
    logic          wb_cyc;
    logic          wb_stb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.NM(NM), .AW(AW), .TMO_W(TMO_W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_m_adr  ({M1_ADR, M0_ADR}),
        .i_m_dat  ({M1_DAT, M0_DAT}),
        .i_m_sel  ({M1_SEL, M0_SEL}),
        .i_m_we   (m_we),
        .i_m_cyc  (m_cyc),
        .i_m_stb  (m_stb),
        .o_m_rdt  (m_rdt),
        .o_m_ack  (m_ack),
        .o_m_err  (m_err),
        .o_wb_adr (wb_adr),
        .o_wb_dat (wb_dat),
        .o_wb_sel (wb_sel),
        .o_wb_we  (wb_we),
        .o_wb_cyc (wb_cyc),
        .o_wb_stb (wb_stb),
        .i_wb_rdt (wb_rdt),
        .i_wb_ack (wb_ack),
        .i_wb_err (wb_err)
    );

    typedef struct {
        string      name;
        logic       rst_n;
        logic [1:0] cyc;
        logic [1:0] stb;
        logic [1:0] we;
        logic       ack;
        logic       err;
        int         own;
        logic       e_cyc;
        logic       e_stb;
        logic [1:0] e_ack;
        logic [1:0] e_err;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic r, input logic [1:0] c, input logic [1:0] s,
                                input logic [1:0] w, input logic a, input logic e, input int own,
                                input logic ec, input logic es, input logic [1:0] ea, input logic [1:0] ee);
        vec_t v;
        v.name = nm; v.rst_n = r; v.cyc = c; v.stb = s; v.we = w; v.ack = a; v.err = e;
        v.own = own; v.e_cyc = ec; v.e_stb = es; v.e_ack = ea; v.e_err = ee;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  ea;
        logic [31:0] ed;
        logic [3:0]  es;
        logic        ew;
        int          cnt [2];
        bit          drop [2];
        int          acks;
        int          last;
        int          own;
        int          bad;

        //         name          rst cyc    stb    we     ack   err  own cyc  stb  ack    err
        vt.push_back(mk("rst_hold",   0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("rst_resp",   0, 2'b11, 2'b11, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("rst_rel",    1, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("first_m0",   1, 2'b11, 2'b11, 2'b00, 1, 0, 1, 1, 1, 2'b01, 2'b00));
        vt.push_back(mk("m0_rel",     1, 2'b10, 2'b10, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("idle_gap",   1, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("m1_ack",     1, 2'b10, 2'b10, 2'b00, 1, 0, 2, 1, 1, 2'b10, 2'b00));
        vt.push_back(mk("m1_rel",     1, 2'b00, 2'b00, 2'b00, 0, 0, 2, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("idle1",      1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("wr_req",     1, 2'b01, 2'b01, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("wr_stb",     1, 2'b01, 2'b01, 2'b01, 0, 0, 1, 1, 1, 2'b00, 2'b00));
        vt.push_back(mk("wr_wait",    1, 2'b01, 2'b01, 2'b01, 0, 0, 1, 1, 1, 2'b00, 2'b00));
        vt.push_back(mk("wr_ack",     1, 2'b01, 2'b01, 2'b01, 1, 0, 1, 1, 1, 2'b01, 2'b00));
        vt.push_back(mk("wr_rel",     1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("idle2",      1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("stray",      1, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("stray_idle", 1, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("m1_err",     1, 2'b10, 2'b10, 2'b10, 0, 1, 2, 1, 1, 2'b00, 2'b10));
        vt.push_back(mk("contend_rel",1, 2'b01, 2'b01, 2'b00, 0, 0, 2, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("contend_idl",1, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("contend_m0", 1, 2'b11, 2'b11, 2'b00, 0, 0, 1, 1, 1, 2'b00, 2'b00));
        vt.push_back(mk("m0_keep",    1, 2'b11, 2'b11, 2'b00, 1, 0, 1, 1, 1, 2'b01, 2'b00));
        vt.push_back(mk("m0_rel2",    1, 2'b10, 2'b10, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("idle3",      1, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vt.push_back(mk("m1_own",     1, 2'b10, 2'b10, 2'b00, 0, 0, 2, 1, 1, 2'b00, 2'b00));

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            rst_n  = vt[i].rst_n;
            m_cyc  = vt[i].cyc;
            m_stb  = vt[i].stb;
            m_we   = vt[i].we;
            wb_ack = vt[i].ack;
            wb_err = vt[i].err;
            #1;
            ea = (vt[i].own == 1) ? M0_ADR : (vt[i].own == 2) ? M1_ADR : '0;
            ed = (vt[i].own == 1) ? M0_DAT : (vt[i].own == 2) ? M1_DAT : '0;
            es = (vt[i].own == 1) ? M0_SEL : (vt[i].own == 2) ? M1_SEL : '0;
            ew = (vt[i].own == 1) ? vt[i].we[0] : (vt[i].own == 2) ? vt[i].we[1] : 1'b0;
            check({vt[i].name, ".cyc"}, 32'(wb_cyc), 32'(vt[i].e_cyc));
            check({vt[i].name, ".stb"}, 32'(wb_stb), 32'(vt[i].e_stb));
            check({vt[i].name, ".ack"}, 32'(m_ack), 32'(vt[i].e_ack));
            check({vt[i].name, ".err"}, 32'(m_err), 32'(vt[i].e_err));
            check({vt[i].name, ".adr"}, 32'(wb_adr), 32'(ea));
            check({vt[i].name, ".dat"}, wb_dat, ed);
            check({vt[i].name, ".sel"}, 32'(wb_sel), 32'(es));
            check({vt[i].name, ".we"},  32'(wb_we), 32'(ew));
        end

        // Asynchronous reset in the middle of m1's transfer.
        wb_ack = 1'b0;
        wb_err = 1'b0;
        @(negedge clk);
        #1;
        check("areset_pre_cyc", 32'(wb_cyc), 32'd1);
        rst_n  = 1'b0;
        wb_ack = 1'b1;
        #1;
        check("areset_cyc", 32'(wb_cyc), 32'd0);
        check("areset_adr", 32'(wb_adr), 32'd0);
        check("areset_ack", 32'(m_ack), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        wb_ack = 1'b0;
        m_cyc  = 2'b00;
        m_stb  = 2'b00;

        // Fairness: both masters keep requesting, each dropping cyc for one cycle after its ack.
        cnt[0] = 0; cnt[1] = 0; drop[0] = 0; drop[1] = 0;
        acks = 0;
        last = -1;
        for (int c = 0; c < 60 && acks < 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                m_cyc[k] = (cnt[k] < 4) && !drop[k];
                m_stb[k] = m_cyc[k];
                drop[k]  = 1'b0;
            end
            wb_ack = 1'b0;
            #1;
            wb_ack = wb_stb;
            wb_rdt = 32'hD0D0_0000 + 32'(c);
            #1;
            if (m_ack != 2'b00) begin
                own = (m_ack == 2'b10) ? 1 : 0;
                check("fair_owner", 32'(own), 32'(acks % 2));
                check("fair_rdt", m_rdt, 32'hD0D0_0000 + 32'(c));
                if (last >= 0) begin
                    check("fair_gap", 32'(c - last), 32'd3);
                end
                last = c;
                drop[own] = 1'b1;
                cnt[own]++;
                acks++;
            end
        end
        check("fair_count", 32'(acks), 32'd8);
        wb_ack = 1'b0;
        m_cyc  = 2'b00;
        m_stb  = 2'b00;
        @(negedge clk);
        @(negedge clk);

        // Unresponsive slave: m0 owns the bus, m1 waits behind it.
        m_cyc = 2'b11;
        m_stb = 2'b11;
        m_we  = 2'b00;
        #1;
        check("tmo_idle", 32'(wb_cyc), 32'd0);
        bad = 0;
`ifdef WB_ARB_TIMEOUT_EN
        for (int s = 0; s < 15; s++) begin
            @(negedge clk);
            #1;
            if (wb_cyc !== 1'b1 || m_err !== 2'b00 || wb_adr !== M0_ADR) bad++;
        end
        check("tmo_stall_cycles_bad", 32'(bad), 32'd0);
        @(negedge clk);
        #1;
        check("tmo_err", 32'(m_err), 32'h1);
        check("tmo_cut_cyc", 32'(wb_cyc), 32'd0);
        @(negedge clk);
        wb_ack = 1'b1;
        #1;
        check("terr_ack_blocked", 32'(m_ack), 32'd0);
        check("terr_err_clear", 32'(m_err), 32'd0);
        check("terr_cyc", 32'(wb_cyc), 32'd0);
        wb_ack = 1'b0;
`else
        for (int s = 0; s < 100; s++) begin
            @(negedge clk);
            #1;
            if (wb_cyc !== 1'b1 || m_err !== 2'b00 || wb_adr !== M0_ADR) bad++;
        end
        check("hold_cycles_bad", 32'(bad), 32'd0);
`endif
        @(negedge clk);
        m_cyc = 2'b10;
        m_stb = 2'b10;
        #1;
        check("tmo_m0_rel_cyc", 32'(wb_cyc), 32'd0);
        @(negedge clk);
        #1;
        check("tmo_idle_gap", 32'(wb_cyc), 32'd0);
        @(negedge clk);
        #1;
        check("tmo_m1_cyc", 32'(wb_cyc), 32'd1);
        check("tmo_m1_adr", 32'(wb_adr), 32'(M1_ADR));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
